// File: rtl/video_pkg.sv
// Shared constants, types and helpers for the BT.601 full-range YCbCr -> RGB decode path.
package video_pkg;

    localparam int SUPPORTED_DEPTH = 8;

    // Inverse BT.601 full-range coefficients in Q8 fixed point.
    localparam logic signed [17:0] K_RCR = 18'sd359;
    localparam logic signed [17:0] K_GCB = 18'sd88;
    localparam logic signed [17:0] K_GCR = 18'sd183;
    localparam logic signed [17:0] K_BCB = 18'sd454;

    localparam logic signed [18:0] ROUND_Q8 = 19'sd128;

    // Default chroma used for a missing Cr at the tail of an odd-length line.
    localparam logic [7:0] NEUTRAL_C_DFLT = 8'd128;

    // Chroma zero point; also the chroma fed to the datapath during blanking.
    localparam logic [7:0] CHROMA_ZERO = 8'd128;

    typedef struct packed {
        logic dv;
        logic hs;
        logic vs;
    } sync_t;

    typedef enum logic {
        PH_EVEN = 1'b0,
        PH_ODD  = 1'b1
    } phase_e;

    typedef struct packed {
        phase_e     ph;
        logic [7:0] cb_hold;
        logic [7:0] cr_hold;
    } pair_dbg_t;

    function automatic logic [7:0] clamp8(input logic signed [10:0] v);
        logic [7:0] res;
        if (v < 11'sd0) begin
            res = 8'd0;
        end else if (v > 11'sd255) begin
            res = 8'd255;
        end else begin
            res = v[7:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/ycbcr2rgb_if.sv
// Pixel stream bundle for the YCbCr -> RGB decoder: raw 4:2:2 stream in, RGB stream out.
interface ycbcr2rgb_if;
    import video_pkg::*;

    // Streams have no backpressure: dv qualifies the pixel in the same cycle and the
    // sink must take every dv-high beat; hs/vs are carried alongside and never gated.
    logic [15:0] ycc_i;
    logic        dv_i;
    logic        hs_i;
    logic        vs_i;

    logic [23:0] rgb_o;
    logic        dv_o;
    logic        hs_o;
    logic        vs_o;
    logic        line_end_o;

    pair_dbg_t   dbg;

    modport master (
        output ycc_i, dv_i, hs_i, vs_i,
        input  rgb_o, dv_o, hs_o, vs_o, line_end_o, dbg
    );

    modport slave (
        input  ycc_i, dv_i, hs_i, vs_i,
        output rgb_o, dv_o, hs_o, vs_o, line_end_o, dbg
    );

endinterface

// File: rtl/ycbcr2rgb_chroma_pair.sv
// Chroma pairing front stage: tracks even/odd pixel phase, registers stage A and
// reconstructs the full (Cb, Cr) pair for the pixel currently held in stage A.
module ycc_chroma_pair
    import video_pkg::*;
#(
    parameter logic [7:0] NEUTRAL_C = NEUTRAL_C_DFLT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ycc,
    input  sync_t       pix_sync,
    output logic [7:0]  a_y,
    output sync_t       a_sync,
    output logic [7:0]  cb,
    output logic [7:0]  cr,
    output pair_dbg_t   dbg
);

    phase_e     ph;
    phase_e     ph_nxt;
    phase_e     a_ph;
    logic [7:0] a_c;
    logic [7:0] cb_hold;
    logic [7:0] cr_hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph <= PH_EVEN;
        end else begin
            ph <= ph_nxt;
        end
    end

    // Any blank cycle re-arms the phase so every line opens on a Cb sample.
    always_comb begin
        ph_nxt = PH_EVEN;
        if (pix_sync.dv) begin
            ph_nxt = (ph == PH_EVEN) ? PH_ODD : PH_EVEN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_y    <= '0;
            a_c    <= '0;
            a_ph   <= PH_EVEN;
            a_sync <= '0;
        end else begin
            a_y    <= ycc[15:8];
            a_c    <= ycc[7:0];
            a_ph   <= pix_sync.dv ? ph : PH_EVEN;
            a_sync <= pix_sync;
        end
    end

    // An even pixel borrows Cr from its partner, which sits on the input this cycle;
    // if the line ended instead, the neutral chroma stands in.
    always_comb begin
        cb = CHROMA_ZERO;
        cr = CHROMA_ZERO;
        if (a_sync.dv) begin
            if (a_ph == PH_EVEN) begin
                cb = a_c;
                cr = NEUTRAL_C;
                if (pix_sync.dv && ph == PH_ODD) begin
                    cr = ycc[7:0];
                end
            end else begin
                cb = cb_hold;
                cr = a_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cb_hold <= NEUTRAL_C;
            cr_hold <= NEUTRAL_C;
        end else if (a_sync.dv && a_ph == PH_EVEN) begin
            cb_hold <= cb;
            cr_hold <= cr;
        end
    end

    assign dbg = {ph, cb_hold, cr_hold};

endmodule

// File: rtl/ycbcr2rgb.sv
// 4:2:2 YCbCr to 24-bit RGB decoder (BT.601 full range) with a fixed 3-cycle latency
// and sync pass-through matched to the data path.
module ycbcr2rgb
    import video_pkg::*;
#(
    parameter int         COLORDEPTH = 8,
    parameter logic [7:0] NEUTRAL_C  = NEUTRAL_C_DFLT,
    parameter bit         BLANK_ZERO = 1'b1
) (
    input logic        clk,
    input logic        rst,
    ycbcr2rgb_if.slave bus
);

    if (COLORDEPTH != SUPPORTED_DEPTH) begin : g_depth_check
        $error("ycbcr2rgb: only COLORDEPTH = 8 is supported");
    end

    sync_t      pix_sync;
    sync_t      a_sync;
    logic [7:0] a_y;
    logic [7:0] cb;
    logic [7:0] cr;
    pair_dbg_t  pair_dbg;

    assign pix_sync = {bus.dv_i, bus.hs_i, bus.vs_i};

    ycc_chroma_pair #(
        .NEUTRAL_C (NEUTRAL_C)
    ) u_pair (
        .clk      (clk),
        .rst      (rst),
        .ycc      (bus.ycc_i),
        .pix_sync (pix_sync),
        .a_y      (a_y),
        .a_sync   (a_sync),
        .cb       (cb),
        .cr       (cr),
        .dbg      (pair_dbg)
    );

    assign bus.dbg = pair_dbg;

    // Stage M: signed chroma offsets and the four coefficient products.
    logic signed [8:0]  d_cb;
    logic signed [8:0]  d_cr;
    logic signed [17:0] d_cb_x;
    logic signed [17:0] d_cr_x;

    assign d_cb   = $signed({1'b0, cb}) - 9'sd128;
    assign d_cr   = $signed({1'b0, cr}) - 9'sd128;
    assign d_cb_x = {{9{d_cb[8]}}, d_cb};
    assign d_cr_x = {{9{d_cr[8]}}, d_cr};

    logic signed [17:0] m_r;
    logic signed [17:0] m_gb;
    logic signed [17:0] m_gr;
    logic signed [17:0] m_b;
    logic [7:0]         m_y;
    sync_t              m_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_r    <= '0;
            m_gb   <= '0;
            m_gr   <= '0;
            m_b    <= '0;
            m_y    <= '0;
            m_sync <= '0;
        end else begin
            m_r    <= K_RCR * d_cr_x;
            m_gb   <= K_GCB * d_cb_x;
            m_gr   <= K_GCR * d_cr_x;
            m_b    <= K_BCB * d_cb_x;
            m_y    <= a_y;
            m_sync <= a_sync;
        end
    end

    // Stage O: round, then drop the 8 fraction bits; in two's complement that is floor.
    logic signed [18:0] r_acc;
    logic signed [18:0] g_acc;
    logic signed [18:0] b_acc;
    logic signed [10:0] y_s;
    logic signed [10:0] r_sum;
    logic signed [10:0] g_sum;
    logic signed [10:0] b_sum;
    logic [23:0]        rgb_nxt;

    always_comb begin
        y_s   = $signed({3'b000, m_y});
        r_acc = $signed({m_r[17], m_r}) + ROUND_Q8;
        g_acc = $signed({m_gb[17], m_gb}) + $signed({m_gr[17], m_gr}) + ROUND_Q8;
        b_acc = $signed({m_b[17], m_b}) + ROUND_Q8;
        r_sum = y_s + $signed(r_acc[18:8]);
        g_sum = y_s - $signed(g_acc[18:8]);
        b_sum = y_s + $signed(b_acc[18:8]);
        rgb_nxt = {clamp8(r_sum), clamp8(g_sum), clamp8(b_sum)};
        if (BLANK_ZERO && !m_sync.dv) begin
            rgb_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rgb_o      <= '0;
            bus.dv_o       <= 1'b0;
            bus.hs_o       <= 1'b0;
            bus.vs_o       <= 1'b0;
            bus.line_end_o <= 1'b0;
        end else begin
            bus.rgb_o      <= rgb_nxt;
            bus.dv_o       <= m_sync.dv;
            bus.hs_o       <= m_sync.hs;
            bus.vs_o       <= m_sync.vs;
            bus.line_end_o <= bus.dv_o & ~m_sync.dv;
        end
    end

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Self-checking bench for ycbcr2rgb: directed decode cases, a mid-line async reset and
// random lines, all compared each cycle against a line-level arithmetic model.
module tb_ycbcr2rgb;
    import video_pkg::*;

    typedef struct packed {
        logic       dv;
        logic       hs;
        logic       vs;
        logic [7:0] y;
        logic [7:0] c;
    } smp_t;

    localparam int HIST = 4096;

    logic clk = 1'b0;
    logic rst;

    ycbcr2rgb_if bus();

    ycbcr2rgb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    smp_t        hist [HIST];
    int          cyc    = 0;
    int          base   = 0;
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [23:0] exp_q[$];
    int          exp_cyc_q[$];

    // Input history, one entry per clock edge; edges seen while in reset carry nothing.
    always @(posedge clk) begin
        if (cyc < HIST) begin
            hist[cyc] = rst ? {bus.dv_i, bus.hs_i, bus.vs_i, bus.ycc_i} : '0;
        end
        cyc = cyc + 1;
    end

    // Reset wipes the pipeline, so history before it no longer affects the outputs.
    always @(negedge rst) base = cyc;

    function automatic smp_t at(input int i);
        if (i < base || i < 0 || i >= HIST) return '0;
        return hist[i];
    endfunction

    function automatic int fdiv256(input int x);
        if (x >= 0) return x / 256;
        return -((-x + 255) / 256);
    endfunction

    function automatic int clip(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic logic [23:0] decode(input int y, input int cb, input int cr);
        int r, g, b;
        r = clip(y + fdiv256(359 * (cr - 128) + 128));
        g = clip(y - fdiv256(88 * (cb - 128) + 183 * (cr - 128) + 128));
        b = clip(y + fdiv256(454 * (cb - 128) + 128));
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    // Number of active pixels earlier in the same line as sample k.
    function automatic int pos_in_line(input int k);
        int p;
        p = 0;
        while (at(k - 1 - p).dv) p++;
        return p;
    endfunction

    // Expected {rgb, dv, hs, vs, line_end} visible after the edge that made cyc = now.
    function automatic logic [27:0] model_out(input int now);
        smp_t        s, nx, pv;
        int          k, cb, cr;
        logic [23:0] rgb;
        k   = now - 3;
        s   = at(k);
        nx  = at(k + 1);
        pv  = at(k - 1);
        rgb = '0;
        if (s.dv) begin
            if (pos_in_line(k) % 2 == 0) begin
                cb = int'(s.c);
                cr = nx.dv ? int'(nx.c) : 128;
            end else begin
                cb = int'(pv.c);
                cr = int'(s.c);
            end
            rgb = decode(int'(s.y), cb, cr);
        end
        return {rgb, s.dv, s.hs, s.vs, (!s.dv && pv.dv)};
    endfunction

    always @(negedge clk) begin
        logic [27:0] got;
        logic [27:0] want;
        logic [23:0] lit;
        int          lit_cyc;
        got  = {bus.rgb_o, bus.dv_o, bus.hs_o, bus.vs_o, bus.line_end_o};
        want = model_out(cyc);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL cycle %0d: got rgb=%06h dv/hs/vs/le=%b, required rgb=%06h dv/hs/vs/le=%b",
                     cyc, got[27:4], got[3:0], want[27:4], want[3:0]);
        end
        if (!rst) begin
            n_cmp++;
            if (bus.dbg !== {PH_EVEN, 8'd128, 8'd128}) begin
                n_fail++;
                $display("FAIL rst_state: got %h, required %h", bus.dbg, {PH_EVEN, 8'd128, 8'd128});
            end
        end
        while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
            lit     = exp_q.pop_front();
            lit_cyc = exp_cyc_q.pop_front();
            n_cmp++;
            if (lit_cyc != cyc || {bus.dv_o, bus.rgb_o} !== {1'b1, lit}) begin
                n_fail++;
                $display("FAIL literal @%0d (due %0d): got dv=%b rgb=%06h, required dv=1 rgb=%06h",
                         cyc, lit_cyc, bus.dv_o, bus.rgb_o, lit);
            end
        end
    end

    task automatic px(input logic dv, input logic [7:0] y, input logic [7:0] c,
                      input logic hs, input logic vs);
        bus.dv_i  = dv;
        bus.ycc_i = {y, c};
        bus.hs_i  = hs;
        bus.vs_i  = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic px_lit(input logic [7:0] y, input logic [7:0] c, input logic [23:0] rgb);
        exp_q.push_back(rgb);
        exp_cyc_q.push_back(cyc + 3);
        px(1'b1, y, c, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) px(1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    endtask

    initial begin
        rst       = 1'b0;
        bus.ycc_i = '0;
        bus.dv_i  = 1'b0;
        bus.hs_i  = 1'b0;
        bus.vs_i  = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        idle(2);

        // Neutral grey pair, then saturated red, high clamp and low clamp.
        px_lit(8'd128, 8'd128, 24'h808080);
        px_lit(8'd128, 8'd128, 24'h808080);
        idle(1);
        px_lit(8'd76, 8'd85, 24'hFE0000);
        px_lit(8'd76, 8'd255, 24'hFE0000);
        idle(1);
        px_lit(8'd255, 8'd255, 24'hFF79FF);
        px_lit(8'd255, 8'd255, 24'hFF79FF);
        idle(1);
        px_lit(8'd0, 8'd0, 24'h008700);
        px_lit(8'd0, 8'd0, 24'h008700);
        idle(2);

        // Odd-length line: last pixel pairs with the neutral Cr.
        px_lit(8'd128, 8'd128, 24'h808080);
        px_lit(8'd128, 8'd128, 24'h808080);
        px_lit(8'd100, 8'd200, 24'h644BE4);
        idle(4);

        // One-pixel line followed by a one-cycle gap.
        px(1'b1, 8'd30, 8'd220, 1'b0, 1'b0);
        idle(1);

        // Sync pulses in blanking and inside an active run.
        px(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        idle(2);
        px(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
        px(1'b1, 8'd50, 8'd60, 1'b1, 1'b0);
        px(1'b1, 8'd70, 8'd80, 1'b0, 1'b1);
        px(1'b1, 8'd90, 8'd100, 1'b1, 1'b1);
        idle(4);

        // Asynchronous reset between edges while the third pixel of a line is on the input.
        px(1'b1, 8'd10, 8'd20, 1'b0, 1'b0);
        px(1'b1, 8'd30, 8'd40, 1'b0, 1'b0);
        bus.dv_i  = 1'b1;
        bus.ycc_i = {8'd55, 8'd66};
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({bus.rgb_o, bus.dv_o, bus.hs_o, bus.vs_o, bus.line_end_o} !== 28'h0) begin
            n_fail++;
            $display("FAIL rst_async: got rgb=%06h dv=%b le=%b, required all 0",
                     bus.rgb_o, bus.dv_o, bus.line_end_o);
        end
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        px(1'b1, 8'd77, 8'd88, 1'b0, 1'b0);
        idle(1);
        px_lit(8'd76, 8'd85, 24'hFE0000);
        px_lit(8'd76, 8'd255, 24'hFE0000);
        idle(2);

        // Random lines with random gaps and sync activity.
        for (int l = 0; l < 40; l++) begin
            int len;
            int gap;
            len = $urandom_range(1, 9);
            gap = $urandom_range(1, 3);
            for (int p = 0; p < len; p++) begin
                px(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            end
            for (int g = 0; g < gap; g++) begin
                px(1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            end
        end
        idle(8);

        if (exp_cyc_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL literal_pending: got %0d unchecked, required 0", exp_cyc_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
